// File: rtl/thor2022_result_writeback_pkg.sv
// thor2022_result_writeback_pkg: shared types for the result write-back queue
package thor2022_result_writeback_pkg;
  localparam int WB_DEPTH = 4;
  typedef logic [5:0] Regno;
  typedef logic [63:0] Value;
  typedef struct packed {
    Regno rt;
    Regno rt2;
    logic dual;
    Value res;
    Value res_t2;
  } WbEntry;
  typedef enum logic {PRI, SEC} wb_phase_e;
endpackage

// File: rtl/thor2022_wb_fifo.sv
// thor2022_wb_fifo: result entry queue with pointers, occupancy and a flat view for bypass scans
module thor2022_wb_fifo
  import thor2022_result_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  WbEntry                     din,
  output WbEntry                     head,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output WbEntry [DEPTH-1:0]         entries
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr;
  WbEntry [DEPTH-1:0] mem;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign entries = mem;
endmodule

// File: rtl/thor2022_result_writeback.sv
// thor2022_result_writeback: queues ALU result pairs and drains them into the single RF write port,
// with a bypass lookup over writes that are still pending
module thor2022_result_writeback
  import thor2022_result_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [5:0]                 alu_rt,
  input  logic [5:0]                 alu_rt2,
  input  logic                       alu_dual,
  input  logic [63:0]                alu_res,
  input  logic [63:0]                alu_res_t2,
  input  logic                       rf_stall,
  output logic                       rf_we,
  output logic [5:0]                 rf_wr,
  output logic [63:0]                rf_wd,
  input  logic [5:0]                 byp_ra,
  output logic                       byp_hit,
  output logic [63:0]                byp_val,
  output logic [$clog2(DEPTH+1)-1:0] wb_count,
  output logic                       wb_idle
);
  localparam int AW = $clog2(DEPTH);
  wb_phase_e phase, phase_d;
  WbEntry head, din, e;
  WbEntry [DEPTH-1:0] entries;
  logic [AW-1:0] rd_ptr;
  logic empty, push, pop, step;
  Regno target;
  Value data;
  assign din = '{rt: alu_rt, rt2: alu_rt2, dual: alu_dual, res: alu_res, res_t2: alu_res_t2};
  assign alu_ready = (wb_count < ($clog2(DEPTH+1))'(DEPTH));
  assign push = alu_valid & alu_ready & ~flush;
  assign step = ~empty & ~rf_stall;
  assign pop  = step & ~flush & ((phase == SEC) | ~head.dual);
  thor2022_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .din    (din),
    .head   (head),
    .rd_ptr (rd_ptr),
    .count  (wb_count),
    .empty  (empty),
    .entries(entries)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PRI;
    else phase <= phase_d;
  end
  always_comb begin
    phase_d = phase;
    if (flush) phase_d = PRI;
    else if (step) phase_d = (phase == PRI && head.dual) ? SEC : PRI;
  end
  assign target  = (phase == SEC) ? head.rt2 : head.rt;
  assign data    = (phase == SEC) ? head.res_t2 : head.res;
  assign rf_we   = step & (target != '0);
  assign rf_wr   = empty ? '0 : target;
  assign rf_wd   = empty ? '0 : data;
  assign wb_idle = empty;
  // Scan oldest to youngest so later matches override; rt2 is checked after rt within an entry.
  always_comb begin
    byp_hit = 1'b0;
    byp_val = '0;
    e = '0;
    for (int k = 0; k < DEPTH; k++) begin
      e = entries[rd_ptr + AW'(k)];
      if (k < int'(wb_count) && byp_ra != '0) begin
        if (!(k == 0 && phase == SEC) && e.rt == byp_ra) begin
          byp_hit = 1'b1;
          byp_val = e.res;
        end
        if (e.dual && e.rt2 == byp_ra) begin
          byp_hit = 1'b1;
          byp_val = e.res_t2;
        end
      end
    end
  end
endmodule
